// File: rtl/cv32e40p_lsu_resp.sv
// Load/store unit front end: issues EX requests on the OBI data bus, tracks up to
// DEPTH outstanding transactions and formats the load data returned for EX/WB.
module cv32e40p_lsu_resp #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        lsu_en_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] data_addr_ex_i,
    input  logic [31:0] data_wdata_ex_i,

    output logic        lsu_ready_ex_o,
    output logic        lsu_ready_wb_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_misaligned_o,
    output logic        busy_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Info word layout: [5] we, [4:3] type, [2] sign_ext, [1:0] byte offset.
    logic [5:0]    fifo_q [DEPTH];
    logic [5:0]    fifo_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          misaligned;
    logic          push;
    logic          pop;
    logic [5:0]    head;
    logic [1:0]    head_type;
    logic          head_sign;
    logic [1:0]    head_off;
    logic [31:0]   shifted;
    logic [31:0]   fmt_data;
    logic [1:0]    off;

    assign off = data_addr_ex_i[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (data_type_ex_i)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Handshake: a transaction is accepted in any cycle with data_req_o & data_gnt_i;
    // the EX request fields are held stable by EX until lsu_ready_ex_o is seen high.
    assign data_req_o       = lsu_en_i & ~misaligned & (cnt_q < DEPTH_C);
    assign push             = data_req_o & data_gnt_i;
    assign pop              = data_rvalid_i & (cnt_q != '0);
    assign lsu_misaligned_o = lsu_en_i & misaligned;
    assign lsu_ready_ex_o   = ~lsu_en_i | push | misaligned;
    assign lsu_ready_wb_o   = (cnt_q == '0) | data_rvalid_i;
    assign busy_o           = (cnt_q != '0) | data_req_o;
    assign lsu_err_o        = data_rvalid_i & data_err_i;

    assign data_addr_o = {data_addr_ex_i[31:2], 2'b00};
    assign data_we_o   = data_we_ex_i;

    always_comb begin
        data_be_o = 4'b1111;
        case (data_type_ex_i)
            2'b01:   data_be_o = 4'b0011 << off;
            2'b10:   data_be_o = 4'b0001 << off;
            default: data_be_o = 4'b1111;
        endcase
    end

    always_comb begin
        data_wdata_o = data_wdata_ex_i;
        case (off)
            2'd1:    data_wdata_o = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
            2'd2:    data_wdata_o = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
            2'd3:    data_wdata_o = {data_wdata_ex_i[7:0],  data_wdata_ex_i[31:8]};
            default: data_wdata_o = data_wdata_ex_i;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = {data_we_ex_i, data_type_ex_i, data_sign_ext_ex_i, off};
            wptr_d         = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fifo_q <= fifo_d;
        end
    end

    // Response formatting uses the head entry, i.e. the oldest accepted request.
    assign head      = fifo_q[rptr_q];
    assign head_type = head[4:3];
    assign head_sign = head[2];
    assign head_off  = head[1:0];
    assign shifted   = data_rdata_i >> {head_off, 3'b000};

    always_comb begin
        fmt_data = data_rdata_i;
        case (head_type)
            2'b10:   fmt_data = {{24{head_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   fmt_data = {{16{head_sign & shifted[15]}}, shifted[15:0]};
            default: fmt_data = data_rdata_i;
        endcase
    end

    assign lsu_rdata_o = data_rvalid_i ? fmt_data : 32'h0;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) !(data_rvalid_i && (cnt_q == '0))
    ) else $error("data_rvalid_i with no outstanding transaction");

endmodule
